// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 8-bit RISC-RNS core.
// Owns the program counter, the instruction register and the {gt,lt,eq,carry}
// flag register. Resolves every jump type in WB and gates the one-cycle
// register-file and data-memory write strobes. Stalls in EXEC while the RNS
// datapath reports a multi-cycle operation in progress.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   instr_valid/instr_in  instruction memory handshake, sampled in FETCH only
//   write_to_regfile,
//   store_true,
//   add_op_true,
//   compare_true          decoder controls for the current instr_reg
//   jump_true,
//   unconditional_jump,
//   jump_gt/lt/eq/carry   decoder jump controls
//   branch_addr           decoded jump target
//   alu_gt/lt/eq/carry    ALU flags, valid in the last EXEC cycle
//   alu_busy              multi-cycle RNS operation in progress
//   prog_ctr              fetch address
//   fetch_req             fetch request (Moore output of FETCH)
//   instr_reg             latched instruction, drives the decoder
//   regfile_we, mem_we    write strobes, only ever high in WB
//   flags                 {gt, lt, eq, carry}
//   halted                sequencer stopped until reset
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [15:0]     instr_in,
    input  logic            write_to_regfile,
    input  logic            store_true,
    input  logic            add_op_true,
    input  logic            compare_true,
    input  logic            jump_true,
    input  logic            unconditional_jump,
    input  logic            jump_gt,
    input  logic            jump_lt,
    input  logic            jump_eq,
    input  logic            jump_carry,
    input  logic [PC_W-1:0] branch_addr,
    input  logic            alu_gt,
    input  logic            alu_lt,
    input  logic            alu_eq,
    input  logic            alu_carry,
    input  logic            alu_busy,
    output logic [PC_W-1:0] prog_ctr,
    output logic            fetch_req,
    output logic [15:0]     instr_reg,
    output logic            regfile_we,
    output logic            mem_we,
    output logic [3:0]      flags,
    output logic            halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [4:0] HALT_OPCODE = 5'b11111;

    // Bit positions inside the flag register.
    localparam int FLAG_GT = 3;
    localparam int FLAG_LT = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_C  = 0;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      flags_q, flags_d;
    logic            branch_taken;

    // jump_true is a summary of the individual jump controls; the individual
    // controls already carry all the information needed to resolve a branch.
    logic            unused_jump_true;
    assign unused_jump_true = jump_true;

    // Branch conditions look at the flags held before this WB edge, so a
    // compare and a jump asserted together can never race.
    assign branch_taken = unconditional_jump
                        | (jump_gt    & flags_q[FLAG_GT])
                        | (jump_lt    & flags_q[FLAG_LT])
                        | (jump_eq    & flags_q[FLAG_EQ])
                        | (jump_carry & flags_q[FLAG_C]);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;

        unique case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (ir_q[15:11] == HALT_OPCODE) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (!alu_busy) begin
                    state_d = ST_WB;
                end
            end

            ST_WB: begin
                if (compare_true) begin
                    flags_d = {alu_gt, alu_lt, alu_eq, alu_carry};
                end else if (add_op_true) begin
                    flags_d[FLAG_C] = alu_carry;
                end

                // The increment wraps naturally at 2^PC_W.
                if (branch_taken) begin
                    pc_d = branch_addr;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end

                state_d = ST_FETCH;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from the registered state; the decoder controls only
    // reach the strobes while the state register says WB.
    // -----------------------------------------------------------------------
    assign fetch_req  = (state_q == ST_FETCH);
    assign halted     = (state_q == ST_HALT);
    assign regfile_we = (state_q == ST_WB) && write_to_regfile;
    assign mem_we     = (state_q == ST_WB) && store_true;
    assign prog_ctr   = pc_q;
    assign instr_reg  = ir_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Drives instr_sequencer with a table of single-instruction records (decoder
// controls, ALU flags, stall and busy counts, expected PC/flags/strobes) and a
// few hand-written sequences for HALT and reset in the middle of EXEC.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    // Decoder control bundle: {wr, st, add, cmp, uj, jgt, jlt, jeq, jc}
    localparam logic [8:0] C_WR  = 9'b1_0000_0000;
    localparam logic [8:0] C_ST  = 9'b0_1000_0000;
    localparam logic [8:0] C_ADD = 9'b0_0100_0000;
    localparam logic [8:0] C_CMP = 9'b0_0010_0000;
    localparam logic [8:0] C_UJ  = 9'b0_0001_0000;
    localparam logic [8:0] C_JGT = 9'b0_0000_1000;
    localparam logic [8:0] C_JLT = 9'b0_0000_0100;
    localparam logic [8:0] C_JEQ = 9'b0_0000_0010;
    localparam logic [8:0] C_JC  = 9'b0_0000_0001;

    typedef struct {
        string       name;
        logic        do_reset;
        logic [15:0] instr;
        logic [8:0]  ctl;
        logic [9:0]  baddr;
        logic [3:0]  alu;        // {gt, lt, eq, carry}
        int          busy;       // EXEC cycles with alu_busy high
        int          stalls;     // FETCH cycles with instr_valid low
        logic [9:0]  exp_pc;
        logic [3:0]  exp_flags;
        int          exp_rf;
        int          exp_mem;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr_in;
    logic        write_to_regfile, store_true, add_op_true, compare_true;
    logic        jump_true, unconditional_jump, jump_gt, jump_lt, jump_eq, jump_carry;
    logic [9:0]  branch_addr;
    logic        alu_gt, alu_lt, alu_eq, alu_carry, alu_busy;
    logic [9:0]  prog_ctr;
    logic        fetch_req;
    logic [15:0] instr_reg;
    logic        regfile_we, mem_we;
    logic [3:0]  flags;
    logic        halted;

    int checks = 0;
    int errors = 0;
    vec_t vecs[20];

    instr_sequencer #(
        .PC_W     (10),
        .RESET_PC (10'h000)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .instr_valid        (instr_valid),
        .instr_in           (instr_in),
        .write_to_regfile   (write_to_regfile),
        .store_true         (store_true),
        .add_op_true        (add_op_true),
        .compare_true       (compare_true),
        .jump_true          (jump_true),
        .unconditional_jump (unconditional_jump),
        .jump_gt            (jump_gt),
        .jump_lt            (jump_lt),
        .jump_eq            (jump_eq),
        .jump_carry         (jump_carry),
        .branch_addr        (branch_addr),
        .alu_gt             (alu_gt),
        .alu_lt             (alu_lt),
        .alu_eq             (alu_eq),
        .alu_carry          (alu_carry),
        .alu_busy           (alu_busy),
        .prog_ctr           (prog_ctr),
        .fetch_req          (fetch_req),
        .instr_reg          (instr_reg),
        .regfile_we         (regfile_we),
        .mem_we             (mem_we),
        .flags              (flags),
        .halted             (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rst, input logic [15:0] instr,
                                input logic [8:0] ctl, input logic [9:0] baddr,
                                input logic [3:0] alu, input int busy, input int stalls,
                                input logic [9:0] exp_pc, input logic [3:0] exp_flags,
                                input int exp_rf, input int exp_mem);
        vec_t v;
        v.name = name;       v.do_reset = rst;     v.instr = instr;
        v.ctl = ctl;         v.baddr = baddr;      v.alu = alu;
        v.busy = busy;       v.stalls = stalls;    v.exp_pc = exp_pc;
        v.exp_flags = exp_flags;  v.exp_rf = exp_rf;  v.exp_mem = exp_mem;
        return v;
    endfunction

    task automatic drive_ctl(input logic [8:0] ctl, input logic [9:0] baddr, input logic [3:0] alu);
        {write_to_regfile, store_true, add_op_true, compare_true,
         unconditional_jump, jump_gt, jump_lt, jump_eq, jump_carry} = ctl;
        jump_true   = |ctl[4:0];
        branch_addr = baddr;
        {alu_gt, alu_lt, alu_eq, alu_carry} = alu;
    endtask

    // Asserts reset in the middle of a cycle, checks the asynchronous reset
    // values, and releases it on a falling edge with the DUT in FETCH.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check({tag, ".rst_pc"},    prog_ctr,  10'h000);
        check({tag, ".rst_outs"},  {fetch_req, halted, regfile_we, mem_we}, 4'b1000);
        check({tag, ".rst_flags"}, flags,     4'b0000);
        check({tag, ".rst_ir"},    instr_reg, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one instruction from a FETCH cycle back to the next FETCH cycle.
    // Called on a falling edge with the DUT in FETCH.
    task automatic run_vec(input vec_t v, input logic [9:0] start_pc);
        int k;
        int rf_cnt;
        int mem_cnt;
        int rf_k;
        bit done;
        if (v.do_reset) do_reset(v.name);
        drive_ctl(v.ctl, v.baddr, v.alu);
        instr_in = v.instr;
        alu_busy = 1'b0;
        for (int s = 0; s < v.stalls; s++) begin
            instr_valid = 1'b0;
            @(negedge clk);
            check({v.name, ".stall"}, {fetch_req, prog_ctr}, {1'b1, start_pc});
        end
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr_in    = 16'hDEAD;
        check({v.name, ".ir"}, instr_reg, v.instr);

        k = 1; rf_cnt = 0; mem_cnt = 0; rf_k = -1; done = 1'b0;
        while (!done && k < 60) begin
            if (regfile_we) begin rf_cnt++; rf_k = k; end
            if (mem_we) mem_cnt++;
            if (fetch_req || halted) begin
                done = 1'b1;
            end else begin
                alu_busy = (k >= 2) && (k < 2 + v.busy);
                @(negedge clk);
                k++;
            end
        end
        alu_busy = 1'b0;

        check({v.name, ".cycles"}, v.stalls + k, 4 + v.busy + v.stalls);
        check({v.name, ".rf_we"},  rf_cnt,  v.exp_rf);
        check({v.name, ".mem_we"}, mem_cnt, v.exp_mem);
        check({v.name, ".pc"},     prog_ctr, v.exp_pc);
        check({v.name, ".flags"},  flags,    v.exp_flags);
        if (v.exp_rf == 1) check({v.name, ".rf_we_in_wb"}, rf_k, 3 + v.busy);
    endtask

    initial begin
        logic [9:0] pc_now;

        reset = 1'b1;
        instr_valid = 1'b0;
        instr_in = 16'h0000;
        alu_busy = 1'b0;
        drive_ctl(9'b0, 10'h000, 4'b0000);

        //            name         rst instr     ctl            baddr   alu      busy stl exp_pc  flags    rf mem
        vecs[0]  = mk("add0",      1, 16'h0801, C_WR|C_ADD,    10'h000, 4'b0000, 0, 0, 10'h001, 4'b0000, 1, 0);
        vecs[1]  = mk("add1",      0, 16'h0802, C_WR|C_ADD,    10'h000, 4'b0000, 0, 0, 10'h002, 4'b0000, 1, 0);
        vecs[2]  = mk("add2",      0, 16'h0803, C_WR|C_ADD,    10'h000, 4'b0000, 0, 0, 10'h003, 4'b0000, 1, 0);
        vecs[3]  = mk("add3",      0, 16'h0804, C_WR|C_ADD,    10'h000, 4'b0000, 0, 0, 10'h004, 4'b0000, 1, 0);
        vecs[4]  = mk("add4_c",    0, 16'h0805, C_WR|C_ADD,    10'h000, 4'b0001, 0, 0, 10'h005, 4'b0001, 1, 0);
        vecs[5]  = mk("jmp",       1, 16'h3800, C_UJ,          10'h155, 4'b0000, 0, 0, 10'h155, 4'b0000, 0, 0);
        vecs[6]  = mk("cmp_eq",    0, 16'h1800, C_CMP,         10'h000, 4'b0010, 0, 0, 10'h156, 4'b0010, 0, 0);
        vecs[7]  = mk("jmpeq_t",   0, 16'h4000, C_JEQ,         10'h020, 4'b1000, 0, 0, 10'h020, 4'b0010, 0, 0);
        vecs[8]  = mk("cmp_gt",    0, 16'h1800, C_CMP,         10'h000, 4'b1000, 0, 0, 10'h021, 4'b1000, 0, 0);
        vecs[9]  = mk("jmpeq_nt",  0, 16'h4000, C_JEQ,         10'h100, 4'b0000, 0, 0, 10'h022, 4'b1000, 0, 0);
        vecs[10] = mk("jmpgt_t",   0, 16'h4800, C_JGT,         10'h3FF, 4'b0000, 0, 0, 10'h3FF, 4'b1000, 0, 0);
        vecs[11] = mk("add_wrap",  0, 16'h0800, C_WR|C_ADD,    10'h000, 4'b0001, 0, 2, 10'h000, 4'b1001, 1, 0);
        vecs[12] = mk("sub_busy",  0, 16'h1000, C_WR,          10'h000, 4'b0000, 3, 0, 10'h001, 4'b1001, 1, 0);
        vecs[13] = mk("jmpc_t",    0, 16'h5800, C_JC,          10'h0AA, 4'b0000, 0, 0, 10'h0AA, 4'b1001, 0, 0);
        vecs[14] = mk("cmp_jlt",   0, 16'h1800, C_CMP|C_JLT,   10'h300, 4'b0100, 0, 0, 10'h0AB, 4'b0100, 0, 0);
        vecs[15] = mk("jmplt_t",   0, 16'h5000, C_JLT,         10'h300, 4'b0000, 0, 0, 10'h300, 4'b0100, 0, 0);
        vecs[16] = mk("store",     0, 16'h2000, C_ST,          10'h000, 4'b0000, 0, 0, 10'h301, 4'b0100, 0, 1);
        vecs[17] = mk("nop",       0, 16'h0000, 9'b0,          10'h000, 4'b1111, 0, 0, 10'h302, 4'b0100, 0, 0);
        vecs[18] = mk("jmpgt_nt",  0, 16'h4800, C_JGT,         10'h155, 4'b1000, 0, 0, 10'h303, 4'b0100, 0, 0);
        vecs[19] = mk("jmp_123",   1, 16'h3800, C_UJ,          10'h123, 4'b0000, 0, 0, 10'h123, 4'b0000, 0, 0);

        repeat (2) @(negedge clk);
        pc_now = 10'h000;
        for (int i = 0; i < 19; i++) begin
            run_vec(vecs[i], vecs[i].do_reset ? 10'h000 : pc_now);
            pc_now = vecs[i].exp_pc;
        end

        // HALT opcode with write/store controls asserted: the sequencer must
        // stop, drop fetch_req and never strobe, even with instr_valid high.
        drive_ctl(C_WR | C_ST, 10'h000, 4'b0000);
        instr_in    = 16'hF800;
        instr_valid = 1'b1;
        @(negedge clk);
        check("halt.ir", instr_reg, 16'hF800);
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            check("halt.outs", {halted, fetch_req, regfile_we, mem_we}, 4'b1000);
            @(negedge clk);
        end
        check("halt.pc", prog_ctr, pc_now);
        instr_valid = 1'b0;

        // Reset leaves HALT; then jump somewhere non-zero.
        run_vec(vecs[19], 10'h000);

        // Reset in the middle of EXEC of a stalled STORE: no strobe, PC back
        // to the reset value, fetch restarts.
        drive_ctl(C_ST, 10'h000, 4'b0000);
        instr_in    = 16'h2000;
        instr_valid = 1'b1;
        alu_busy    = 1'b1;
        @(negedge clk);                 // DECODE
        instr_valid = 1'b0;
        @(negedge clk);                 // EXEC, held by alu_busy
        check("exec_rst.pre_pc", prog_ctr, 10'h123);
        reset = 1'b1;
        #1;
        check("exec_rst.outs", {fetch_req, halted, mem_we}, 3'b100);
        check("exec_rst.pc",   prog_ctr, 10'h000);
        @(negedge clk);
        reset    = 1'b0;
        alu_busy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("exec_rst.idle", {fetch_req, mem_we, prog_ctr}, {2'b10, 10'h000});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
